// File: rtl/dot_product_pkg.sv
// Shared constants, reader state encoding and MEM3 depth helper for dot_product_system.
package dot_product_pkg;

  localparam int DATA_W      = 8;
  localparam int VEC_W       = 4;
  localparam int AB_DEPTH    = 32;
  localparam int AB_ADDR_W   = 5;
  localparam int RESULT_W    = 18;
  localparam int MEM3_ADDR_W = 4;
  localparam int MEM3_SZ     = 64;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} rd_state_t;

  // Result store can never hold more slots than its read address can reach.
  function automatic int mem3_depth(input int size, input int aw);
    return (size < (1 << aw)) ? size : (1 << aw);
  endfunction

endpackage

// File: rtl/dot_product_system_sync_ram.sv
// Simple dual-port RAM: one write port, one registered read port (old data on same-address collision).
module sync_ram #(
  parameter int DW    = 8,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dot_product_system.sv
// Dot-product engine: reader FSM + MAC over RAMs A/B, writer commits results to MEM3 ring.
// Optional macro DOT_SATURATE_EN: store all-ones when the result exceeds DATA_WIDTH bits.
module dot_product_system
  import dot_product_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_W,
  parameter int VECTOR_WIDTH    = VEC_W,
  parameter int DEPTH           = AB_DEPTH,
  parameter int ADDR_WIDTH      = AB_ADDR_W,
  parameter int RESULT_WIDTH    = RESULT_W,
  parameter int MEM3_ADDR_WIDTH = MEM3_ADDR_W,
  parameter int MEM3_SIZE       = MEM3_SZ
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       write_en,
  input  logic [ADDR_WIDTH-1:0]      write_addr,
  input  logic [DATA_WIDTH-1:0]      data_a,
  input  logic [DATA_WIDTH-1:0]      data_b,
  input  logic                       start_reading,
  output logic                       reading_done,
  input  logic                       read_en,
  input  logic [MEM3_ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0]      result_out,
  output logic                       writer_busy,
  output logic                       writer_done
);

  localparam int M3_DEPTH = mem3_depth(MEM3_SIZE, MEM3_ADDR_WIDTH);

  typedef struct packed {
    logic                    vld;
    logic [RESULT_WIDTH-1:0] data;
  } commit_t;

  rd_state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]      idx;
  logic                       issue, data_vld;
  logic [DATA_WIDTH-1:0]      a_q, b_q, m3_q, m3_wdata;
  logic [RESULT_WIDTH-1:0]    acc;
  commit_t                    commit;
  logic [MEM3_ADDR_WIDTH-1:0] wptr;
  logic                       m3_we, rd_inrange, oob_q, start_ok;

  assign start_ok = start_reading && (state == IDLE) && !writer_busy;
  assign issue    = (state == READ);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_ok) state_nx = READ;
      READ:    if (idx == ADDR_WIDTH'(VECTOR_WIDTH-1)) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  sync_ram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH), .DEPTH(DEPTH)) u_mem_a (
    .clk(clk), .rst(rst), .we(write_en), .waddr(write_addr), .wdata(data_a),
    .re(issue), .raddr(idx), .rdata(a_q)
  );

  sync_ram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH), .DEPTH(DEPTH)) u_mem_b (
    .clk(clk), .rst(rst), .we(write_en), .waddr(write_addr), .wdata(data_b),
    .re(issue), .raddr(idx), .rdata(b_q)
  );

  // data_vld trails issue by the RAM read latency; the last product lands during DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      data_vld     <= 1'b0;
      acc          <= '0;
      reading_done <= 1'b0;
      commit.vld   <= 1'b0;
    end else begin
      data_vld   <= issue;
      commit.vld <= (state == DONE);
      if (start_ok) begin
        idx          <= '0;
        acc          <= '0;
        reading_done <= 1'b0;
      end else begin
        if (issue)    idx <= idx + 1'b1;
        if (data_vld) acc <= acc + RESULT_WIDTH'(a_q) * RESULT_WIDTH'(b_q);
        if (state == DONE) begin
          reading_done <= 1'b1;
          commit.data  <= acc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      writer_busy <= 1'b0;
      writer_done <= 1'b0;
      wptr        <= '0;
    end else begin
      writer_busy <= commit.vld;
      if (start_ok) writer_done <= 1'b0;
      if (writer_busy) begin
        writer_done <= 1'b1;
        wptr <= (wptr == MEM3_ADDR_WIDTH'(M3_DEPTH-1)) ? '0 : wptr + 1'b1;
      end
    end
  end

`ifdef DOT_SATURATE_EN
  assign m3_wdata = (|commit.data[RESULT_WIDTH-1:DATA_WIDTH]) ? '1 : commit.data[DATA_WIDTH-1:0];
`else
  assign m3_wdata = commit.data[DATA_WIDTH-1:0];
`endif

  // A reset landing on the commit cycle must suppress the store.
  assign m3_we      = writer_busy && !rst;
  assign rd_inrange = ({1'b0, read_addr} < (MEM3_ADDR_WIDTH+1)'(M3_DEPTH));

  sync_ram #(.DW(DATA_WIDTH), .AW(MEM3_ADDR_WIDTH), .DEPTH(M3_DEPTH)) u_mem3 (
    .clk(clk), .rst(rst), .we(m3_we), .waddr(wptr), .wdata(m3_wdata),
    .re(read_en && rd_inrange), .raddr(read_addr), .rdata(m3_q)
  );

  always_ff @(posedge clk) begin
    if (rst)          oob_q <= 1'b0;
    else if (read_en) oob_q <= !rd_inrange;
  end

  assign result_out = oob_q ? '0 : m3_q;

endmodule

// File: tb/tb_dot_product_system.sv
// Self-checking bench for dot_product_system: directed cases plus randomized runs vs a behavioural model.
module tb_dot_product_system;

  logic       clk = 1'b0, rst = 1'b1, write_en = 1'b0, start_reading = 1'b0, read_en = 1'b0;
  logic [4:0] write_addr = '0;
  logic [7:0] data_a = '0, data_b = '0;
  logic [3:0] read_addr = '0;
  logic       reading_done, writer_busy, writer_done;
  logic [7:0] result_out;

  int n_chk = 0, n_pass = 0;
  int m3 [16];
  int wp = 0;

  dot_product_system dut (
    .clk(clk), .rst(rst), .write_en(write_en), .write_addr(write_addr),
    .data_a(data_a), .data_b(data_b), .start_reading(start_reading),
    .reading_done(reading_done), .read_en(read_en), .read_addr(read_addr),
    .result_out(result_out), .writer_busy(writer_busy), .writer_done(writer_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stored value = dot product, then truncated or saturated to 8 bits.
  function automatic int model_store(input int a[4], input int b[4]);
    longint s = 0;
    for (int i = 0; i < 4; i++) s += longint'(a[i]) * longint'(b[i]);
`ifdef DOT_SATURATE_EN
    return (s > 255) ? 255 : int'(s);
`else
    return int'(s % 256);
`endif
  endfunction

  task automatic load_vec(input int a[4], input int b[4]);
    for (int i = 0; i < 4; i++) begin
      write_en = 1'b1; write_addr = 5'(i); data_a = 8'(a[i]); data_b = 8'(b[i]);
      tick();
    end
    write_en = 1'b0;
  endtask

  task automatic read_mem(input int addr, output int v);
    read_en = 1'b1; read_addr = 4'(addr);
    tick();
    read_en = 1'b0;
    v = int'(result_out);
  endtask

  // Full run: load, start, check latency / writer pulse / stored value. extra>=0 re-pulses start mid-run.
  task automatic run_dot(input int a[4], input int b[4], input int extra);
    int lat, busy, v, exp_v;
    bit seen;
    load_vec(a, b);
    exp_v = model_store(a, b);
    start_reading = 1'b1;
    tick();
    start_reading = 1'b0;
    n_chk++;
    if (reading_done !== 1'b0 || writer_done !== 1'b0)
      $display("FAIL start_clears_flags: got rd=%0d wd=%0d want 0/0", reading_done, writer_done);
    else n_pass++;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      start_reading = (lat == extra);
      tick();
      start_reading = 1'b0;
      lat++;
      if (reading_done === 1'b1) seen = 1'b1;
    end
    n_chk++;
    if (!seen || lat != 6) $display("FAIL done_latency: got %0d want 6", seen ? lat : -1);
    else n_pass++;
    busy = 0;
    for (int k = 0; k < 10 && writer_done !== 1'b1; k++) begin
      tick();
      if (writer_busy === 1'b1) busy++;
    end
    n_chk++;
    if (busy != 1 || writer_done !== 1'b1)
      $display("FAIL writer_pulse: got busy_cycles=%0d done=%0d want 1/1", busy, writer_done);
    else n_pass++;
    m3[wp] = exp_v;
    read_mem(wp, v);
    n_chk++;
    if (v != exp_v) $display("FAIL store_slot%0d: got %0d want %0d", wp, v, exp_v);
    else n_pass++;
    wp = (wp + 1) % 16;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_chk++;
    if ({reading_done, writer_busy, writer_done} !== 3'b000 || result_out !== 8'h00)
      $display("FAIL reset_outputs: got rd=%0d wb=%0d wd=%0d out=%0d want 0", reading_done,
               writer_busy, writer_done, result_out);
    else n_pass++;
    rst = 1'b0;
    wp = 0;
    tick();
  endtask

  task automatic test_basic();
    int a[4], b[4], v;
    a = '{1, 2, 3, 4}; b = '{1, 1, 1, 1}; run_dot(a, b, -1);
    a = '{2, 4, 6, 8}; b = '{1, 2, 3, 4}; run_dot(a, b, -1);
    read_mem(0, v);
    n_chk++;
    if (v != 10) $display("FAIL slot0_kept: got %0d want 10", v);
    else n_pass++;
    a = '{0, 5, 0, 3}; b = '{2, 0, 4, 1}; run_dot(a, b, -1);
  endtask

  task automatic test_read_hold();
    int v;
    read_mem(1, v);
    read_en = 1'b0; read_addr = 4'd0;
    tick(); tick();
    n_chk++;
    if (int'(result_out) != m3[1]) $display("FAIL read_hold: got %0d want %0d", result_out, m3[1]);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int a[4], b[4];
    a = '{255, 255, 255, 255}; b = '{255, 255, 255, 255};
    run_dot(a, b, -1);
  endtask

  task automatic test_abort();
    int a[4], b[4], v, y;
    bit bad;
    a = '{3, 1, 4, 1}; b = '{5, 9, 2, 6}; run_dot(a, b, 1);
    // Reset with flags high clears them and rewinds the write pointer.
    rst = 1'b1; tick(); rst = 1'b0; wp = 0;
    n_chk++;
    if (reading_done !== 1'b0 || writer_done !== 1'b0)
      $display("FAIL reset_clears_flags: got rd=%0d wd=%0d want 0/0", reading_done, writer_done);
    else n_pass++;
    start_reading = 1'b1; tick(); start_reading = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (reading_done !== 1'b0 || writer_busy !== 1'b0) bad = 1'b1;
      tick();
    end
    n_chk++;
    if (bad) $display("FAIL abort_mid_read: got activity=1 want 0");
    else n_pass++;
    a = '{7, 7, 7, 7}; b = '{1, 2, 0, 1}; run_dot(a, b, -1);
    y = m3[0];
    // Reset on the commit cycle must leave slot 0 untouched.
    a = '{9, 9, 9, 9}; b = '{1, 1, 1, 1}; load_vec(a, b);
    start_reading = 1'b1; tick(); start_reading = 1'b0;
    for (int k = 0; k < 20 && reading_done !== 1'b1; k++) tick();
    tick();
    n_chk++;
    if (writer_busy !== 1'b1) $display("FAIL busy_before_abort: got %0d want 1", writer_busy);
    else n_pass++;
    rst = 1'b1; tick(); rst = 1'b0; wp = 0;
    read_mem(0, v);
    n_chk++;
    if (v != y) $display("FAIL no_write_on_reset: got %0d want %0d", v, y);
    else n_pass++;
  endtask

  task automatic test_random_wrap();
    int a[4], b[4], v;
    for (int r = 0; r < 17; r++) begin
      for (int i = 0; i < 4; i++) begin
        a[i] = int'($urandom_range(0, 255));
        b[i] = int'($urandom_range(0, 255));
      end
      if (r % 3 == 0) for (int i = 0; i < 4; i++) b[i] = b[i] % 4;
      run_dot(a, b, -1);
    end
    for (int s = 0; s < 16; s++) begin
      read_mem(s, v);
      n_chk++;
      if (v != m3[s]) $display("FAIL wrap_slot%0d: got %0d want %0d", s, v, m3[s]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_read_hold();
    test_overflow();
    test_abort();
    test_random_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
